// File: rtl/stream_cipher_pkg.sv
// Shared types for the stream cipher session controller and datapath.
package stream_cipher_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PROCESS = 3'd2,
    DONE    = 3'd3,
    FAULT   = 3'd4
  } session_state_t;

  // States in which a session is live and the watchdog is allowed to run.
  function automatic logic is_active(input session_state_t s);
    return (s == LOAD) || (s == PROCESS) || (s == DONE);
  endfunction

endpackage

// File: rtl/stream_session_fsm_if.sv
// Host <-> session controller bundle; master is the host side, slave the controller.
interface stream_session_fsm_if import stream_cipher_pkg::*; #(
  parameter int LEN_W = 8
);
  logic             input_request;
  logic [LEN_W-1:0] len_in;
  logic             word_valid;
  logic             output_is_ready;
  logic             output_acknowledge;
  logic             abort;
  session_state_t   state_out;
  logic             load_ready;
  logic [LEN_W-1:0] word_index;
  logic             process_start;
  logic             fault;

  modport master (
    output input_request, len_in, word_valid, output_is_ready, output_acknowledge, abort,
    input  state_out, load_ready, word_index, process_start, fault
  );

  modport slave (
    input  input_request, len_in, word_valid, output_is_ready, output_acknowledge, abort,
    output state_out, load_ready, word_index, process_start, fault
  );
endinterface

// File: rtl/stream_session_fsm_watchdog.sv
// Session watchdog: counts enabled cycles, flags expiry on the TIMEOUT-1 count.
module session_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic nrst,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count_r;

  // Cycle counter, held at zero while idle or on a clear request.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_r <= '0;
    end else if (!enable || clear) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  assign expired = enable && (count_r == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/stream_session_fsm.sv
// Session controller for the stream cipher: IDLE/LOAD/PROCESS/DONE/FAULT.
// Define STREAM_SESSION_TIMEOUT_EN to enable the watchdog and the FAULT state.
module stream_session_fsm import stream_cipher_pkg::*; #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 nrst,
  stream_session_fsm_if.slave  bus
);
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("stream_session_fsm: TIMEOUT must be at least 2");
  end

  session_state_t   state_r, state_next;
  logic [LEN_W-1:0] length_r, length_next;
  logic [LEN_W-1:0] word_index_r, index_next;
  logic             load_ready_r, load_ready_next;
  logic             process_start_r, process_start_next;
  logic             fault_r, fault_next;
  logic             accept_s;
  logic             expired_s;

  assign accept_s = (state_r == LOAD) && bus.word_valid;

`ifdef STREAM_SESSION_TIMEOUT_EN
  logic wd_clear_s;

  // Restart the watchdog on any state change or forward progress in LOAD.
  assign wd_clear_s = (state_next != state_r) || accept_s;

  session_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .nrst    (nrst),
    .enable  (is_active(state_r)),
    .clear   (wd_clear_s),
    .expired (expired_s)
  );
`else
  assign expired_s = 1'b0;
`endif

  // State, counters and Moore outputs, all registered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r         <= IDLE;
      length_r        <= '0;
      word_index_r    <= '0;
      load_ready_r    <= 1'b0;
      process_start_r <= 1'b0;
      fault_r         <= 1'b0;
    end else begin
      state_r         <= state_next;
      length_r        <= length_next;
      word_index_r    <= index_next;
      load_ready_r    <= load_ready_next;
      process_start_r <= process_start_next;
      fault_r         <= fault_next;
    end
  end

  // Next-state logic; abort beats watchdog expiry, which beats normal flow.
  always_comb begin
    state_next  = state_r;
    length_next = length_r;
    index_next  = word_index_r;
    if ((state_r != IDLE) && bus.abort) begin
      state_next  = IDLE;
      length_next = '0;
      index_next  = '0;
    end else if (expired_s) begin
      state_next = FAULT;
      index_next = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.input_request && !bus.abort && (bus.len_in != '0)) begin
            state_next  = LOAD;
            length_next = bus.len_in;
            index_next  = '0;
          end else begin
            state_next = IDLE;
          end
        end
        LOAD: begin
          // Compare against length-1 so a full-scale length never wraps the index.
          if (accept_s && (word_index_r == (length_r - LEN_W'(1)))) begin
            state_next = PROCESS;
            index_next = '0;
          end else if (accept_s) begin
            index_next = word_index_r + LEN_W'(1);
          end else begin
            index_next = word_index_r;
          end
        end
        PROCESS: begin
          if (bus.output_is_ready) begin
            state_next = DONE;
          end else begin
            state_next = PROCESS;
          end
        end
        DONE: begin
          if (bus.output_acknowledge) begin
            state_next = IDLE;
          end else begin
            state_next = DONE;
          end
        end
        FAULT: begin
          if (bus.output_acknowledge) begin
            state_next = IDLE;
          end else begin
            state_next = FAULT;
          end
        end
        default: begin
          state_next  = IDLE;
          length_next = '0;
          index_next  = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs line up with state_r.
  always_comb begin
    load_ready_next    = (state_next == LOAD);
    process_start_next = (state_next == PROCESS) && (state_r != PROCESS);
`ifdef STREAM_SESSION_TIMEOUT_EN
    fault_next         = (state_next == FAULT);
`else
    fault_next         = 1'b0;
`endif
  end

  assign bus.state_out     = state_r;
  assign bus.load_ready    = load_ready_r;
  assign bus.word_index    = word_index_r;
  assign bus.process_start = process_start_r;
  assign bus.fault         = fault_r;
endmodule

// File: tb/tb_stream_session_fsm.sv
// Scoreboard bench for stream_session_fsm: directed steps push expectations, a monitor checks them.
module tb_stream_session_fsm;
  import stream_cipher_pkg::*;

  typedef struct {
    int          target;
    logic [13:0] exp;
    string       name;
  } entry_t;

  logic   clk = 1'b0;
  logic   nrst = 1'b0;
  int     cyc_cnt = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  entry_t exp_q[$];

  stream_session_fsm_if #(.LEN_W(8)) bus ();

  stream_session_fsm #(.LEN_W(8), .TIMEOUT(16)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [13:0] pack(session_state_t s, logic lr, logic [7:0] wi, logic ps, logic f);
    return {s, lr, wi, ps, f};
  endfunction

  function automatic logic [13:0] observed();
    return pack(bus.state_out, bus.load_ready, bus.word_index, bus.process_start, bus.fault);
  endfunction

  task automatic check(string name, logic [13:0] act, logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got st=%0d lr=%0b wi=%0d ps=%0b f=%0b, expected st=%0d lr=%0b wi=%0d ps=%0b f=%0b",
               name, cyc_cnt, act[13:11], act[10], act[9:2], act[1], act[0],
               exp[13:11], exp[10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  // Monitor: compare every expectation whose target cycle has been reached.
  always @(negedge clk) begin
    entry_t e;
    while ((exp_q.size() > 0) && (exp_q[0].target <= cyc_cnt)) begin
      e = exp_q.pop_front();
      check(e.name, observed(), e.exp);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(string name, logic ir, logic [7:0] len, logic wv, logic oir, logic oack, logic ab,
                      session_state_t es, logic elr, logic [7:0] ewi, logic eps, logic ef);
    bus.input_request      = ir;
    bus.len_in             = len;
    bus.word_valid         = wv;
    bus.output_is_ready    = oir;
    bus.output_acknowledge = oack;
    bus.abort              = ab;
    exp_q.push_back('{cyc_cnt + 1, pack(es, elr, ewi, eps, ef), name});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    bus.input_request      = 1'b0;
    bus.len_in             = 8'd0;
    bus.word_valid         = 1'b0;
    bus.output_is_ready    = 1'b0;
    bus.output_acknowledge = 1'b0;
    bus.abort              = 1'b0;
    #1;
    check("reset_state", observed(), pack(IDLE, 1'b0, 8'd0, 1'b0, 1'b0));
    #11 nrst = 1'b1;
    @(posedge clk);
    #1;

    // Basic session, length 3, word_valid held high (also ignored in IDLE).
    step("s3_req",    1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd0, 1'b0, 1'b0);
    step("s3_w0",     1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd1, 1'b0, 1'b0);
    step("s3_w1",     1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd2, 1'b0, 1'b0);
    step("s3_w2",     1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, PROCESS, 1'b0, 8'd0, 1'b1, 1'b0);
    step("s3_proc",   1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, PROCESS, 1'b0, 8'd0, 1'b0, 1'b0);
    step("s3_ready",  1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, DONE,    1'b0, 8'd0, 1'b0, 1'b0);
    step("s3_done",   1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, DONE,    1'b0, 8'd0, 1'b0, 1'b0);
    step("s3_ack",    1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, IDLE,    1'b0, 8'd0, 1'b0, 1'b0);

    // Zero-length request is ignored.
    step("len0_req",  1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,    1'b0, 8'd0, 1'b0, 1'b0);
    step("len0_hold", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,    1'b0, 8'd0, 1'b0, 1'b0);

    // Length 4 with gapped word_valid; early acknowledge in LOAD is ignored.
    step("s4_req",    1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd0, 1'b0, 1'b0);
    step("s4_c1",     1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd1, 1'b0, 1'b0);
    step("s4_c2",     1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, LOAD,    1'b1, 8'd1, 1'b0, 1'b0);
    step("s4_c3",     1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd2, 1'b0, 1'b0);
    step("s4_c4",     1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd2, 1'b0, 1'b0);
    step("s4_c5",     1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd3, 1'b0, 1'b0);
    step("s4_c6",     1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd3, 1'b0, 1'b0);
    step("s4_c7",     1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, PROCESS, 1'b0, 8'd0, 1'b1, 1'b0);

    // Abort in PROCESS beats output_is_ready.
    step("abort_proc", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, IDLE,   1'b0, 8'd0, 1'b0, 1'b0);
    step("abort_idle", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, IDLE,   1'b0, 8'd0, 1'b0, 1'b0);

    // Abort in IDLE blocks a request; abort in LOAD clears the session.
    step("abort_req",  1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, IDLE,   1'b0, 8'd0, 1'b0, 1'b0);
    step("s5_req",     1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, LOAD,   1'b1, 8'd0, 1'b0, 1'b0);
    step("s5_w0",      1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, LOAD,   1'b1, 8'd1, 1'b0, 1'b0);
    step("abort_load", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, IDLE,   1'b0, 8'd0, 1'b0, 1'b0);

    // Length 1: single word goes straight to PROCESS.
    step("s1_req",    1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd0, 1'b0, 1'b0);
    step("s1_w0",     1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, PROCESS, 1'b0, 8'd0, 1'b1, 1'b0);
    step("s1_ready",  1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, DONE,    1'b0, 8'd0, 1'b0, 1'b0);
    step("s1_ack",    1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, IDLE,    1'b0, 8'd0, 1'b0, 1'b0);

    // Full-scale length 255 without index overflow.
    step("s255_req",  1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, LOAD,  1'b1, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 254; i++) begin
      step("s255_load", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, LOAD,  1'b1, 8'(i + 1), 1'b0, 1'b0);
    end
    step("s255_last", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, PROCESS, 1'b0, 8'd0, 1'b1, 1'b0);
    step("s255_rdy",  1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, DONE,    1'b0, 8'd0, 1'b0, 1'b0);
    step("s255_ack",  1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, IDLE,    1'b0, 8'd0, 1'b0, 1'b0);

`ifdef STREAM_SESSION_TIMEOUT_EN
    // Stall in PROCESS: 16 PROCESS cycles, then FAULT until acknowledged.
    step("wd_req",    1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd0, 1'b0, 1'b0);
    step("wd_w0",     1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, PROCESS, 1'b0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step("wd_stall", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, PROCESS, 1'b0, 8'd0, 1'b0, 1'b0);
    end
    step("wd_fault",  1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, FAULT,   1'b0, 8'd0, 1'b0, 1'b1);
    step("wd_hold",   1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, FAULT,   1'b0, 8'd0, 1'b0, 1'b1);
    step("wd_ack",    1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, IDLE,    1'b0, 8'd0, 1'b0, 1'b0);
`endif

    // Asynchronous reset mid-LOAD at word_index 2.
    step("rst_req",   1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd0, 1'b0, 1'b0);
    step("rst_w0",    1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd1, 1'b0, 1'b0);
    step("rst_w1",    1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, LOAD,    1'b1, 8'd2, 1'b0, 1'b0);
    @(negedge clk);
    #1 nrst = 1'b0;
    #1 check("async_reset", observed(), pack(IDLE, 1'b0, 8'd0, 1'b0, 1'b0));
    bus.word_valid = 1'b0;
    #1 nrst = 1'b1;
    @(posedge clk);
    #1;
    step("post_reset", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,   1'b0, 8'd0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_session_fsm.md
STREAM_SESSION_FSM -- requirements
Module: stream_session_fsm

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of message length and word counters.
REQ-002 SHALL have parameter TIMEOUT, default 1024, watchdog limit in cycles (min 2).
REQ-003 SHALL have port clk input 1, clock; reset nrst, asynchronous, active-low.
REQ-004 SHALL have port nrst input 1, asynchronous active-low reset.
REQ-005 SHALL have port input_request input 1, host requests a session.
REQ-006 SHALL have port len_in input LEN_W, message length in words, sampled with input_request.
REQ-007 SHALL have port word_valid input 1, host presents an input word.
REQ-008 SHALL have port output_is_ready input 1, output holder has the result.
REQ-009 SHALL have port output_acknowledge input 1, host has taken the result.
REQ-010 SHALL have port abort input 1, host cancels the session.
REQ-011 SHALL have port state_out output session_state_t, current state.
REQ-012 SHALL have port load_ready output 1, word accepted when word_valid && load_ready.
REQ-013 SHALL have port word_index output LEN_W, index of next word to accept.
REQ-014 SHALL have port process_start output 1, one-cycle pulse on PROCESS entry.
REQ-015 SHALL have port fault output 1, high while in FAULT.

Function
REQ-016 SHALL implement states IDLE, LOAD, PROCESS, DONE, FAULT, registered, Moore outputs.
REQ-017 IDLE: input_request && len_in!=0 -> LOAD, capture len_in into length register; len_in==0 -> request ignored, stay IDLE.
REQ-018 LOAD: load_ready=1; each accepted word increments word_index by 1.
REQ-019 LOAD: accepting word with word_index==length-1 -> PROCESS next cycle; word_index then clears to 0.
REQ-020 PROCESS: process_start=1 on first cycle only; output_is_ready -> DONE.
REQ-021 DONE: output_acknowledge -> IDLE; output_is_ready ignored.
REQ-022 abort SHALL take priority over all other inputs: any non-IDLE state -> IDLE next cycle, word_index and length cleared.
REQ-023 abort in IDLE SHALL block a simultaneous input_request (stay IDLE).
REQ-024 Inputs not relevant to the current state SHALL be ignored (e.g. word_valid outside LOAD, early output_acknowledge).
REQ-025 Length 2^LEN_W-1 SHALL be supported without counter overflow.

Reset
REQ-026 On nrst low: state IDLE, word_index 0, length 0, load_ready 0, process_start 0, fault 0, timer 0; takes effect asynchronously mid-session.

Configuration
REQ-027 Macro STREAM_SESSION_TIMEOUT_EN defined: watchdog counts cycles in LOAD/PROCESS/DONE, clears on state change or accepted word; reaching TIMEOUT-1 -> FAULT next cycle.
REQ-028 With STREAM_SESSION_TIMEOUT_EN: FAULT exits to IDLE on abort or output_acknowledge only.
REQ-029 Without STREAM_SESSION_TIMEOUT_EN: no timer logic, FAULT unreachable, fault tied 0; all other behaviour identical.

Structure
REQ-030 session_state_t enum (IDLE, LOAD, PROCESS, DONE, FAULT) SHALL live in package stream_cipher_pkg, shared with the datapath.
REQ-031 Watchdog SHALL be sub-module session_watchdog (params TIMEOUT; inputs clk, nrst, enable, clear; output expired).

Verification
REQ-032 Reset, then input_request=1 len_in=3, word_valid held high -> LOAD 3 cycles, word_index 0,1,2, PROCESS with process_start pulse, output_is_ready -> DONE, output_acknowledge -> IDLE.
REQ-033 len_in=0 with input_request -> state stays IDLE, load_ready stays 0.
REQ-034 len_in=4, word_valid toggling 1,0,1,0,1,0,1 -> exactly 4 accepts, PROCESS entered after 7th cycle.
REQ-035 abort asserted in PROCESS together with output_is_ready -> IDLE next cycle, word_index 0, no DONE.
REQ-036 TIMEOUT_EN, TIMEOUT=16, stall in PROCESS -> FAULT after 16 cycles, fault=1; output_acknowledge -> IDLE.
REQ-037 nrst pulsed low mid-LOAD (word_index=2) -> IDLE, word_index 0 immediately, without waiting for clk.
